id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/hazard_detect.sv | 37 +++
 rtl/id_ex_reg.sv | 148 ++++++++++++++
 tb/tb_id_ex_reg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared pipeline definitions for the ID/EX stage. Holds the ALU
//            opcode width and codes, the register-index width, and the
//            EX-stage control bundle with a helper that turns it into a bubble.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int unsigned ALUOP_W   = 4;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluop_e;

    // Control bits that travel with the instruction into EX.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
    } ex_ctrl_t;

    // A bubble must not write the register file or touch memory. alusrc only
    // steers an operand mux, so it is left as-is.
    function automatic ex_ctrl_t ctrl_bubble(input ex_ctrl_t c);
        ex_ctrl_t r;
        r          = c;
        r.regwrite = 1'b0;
        r.memread  = 1'b0;
        r.memwrite = 1'b0;
        r.memtoreg = 1'b0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use hazard detector. Flags a stall when the
//            load now in EX writes a register the instruction in ID reads.
// Ports    : ex_valid, ex_memread, ex_rt - load currently in EX
//            id_valid, id_rs, id_rt, id_uses_rt - instruction in ID
//            flush - squash of the decode slot (suppresses the stall)
//            stall - hazard output
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import mips_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 id_valid,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    output logic                 stall
);

    logic w_load_in_ex;
    logic w_src_match;

    // $zero is hard-wired, so a load targeting it never creates a dependency.
    assign w_load_in_ex = ex_valid & ex_memread & (ex_rt != '0);
    assign w_src_match  = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));

    // A flushed decode slot is being discarded anyway; stalling it is pointless.
    assign stall = w_load_in_ex & id_valid & ~flush & w_src_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg
// Purpose  : ID/EX pipeline register with load-use stall insertion and a
//            saturating stall-event counter.
// Ports    : clk, rst (sync, active-high)
//            id_*  - decoded instruction fields from ID
//            flush - taken branch/jump resolved in EX
//            ex_*  - registered fields presented to EX
//            stall - combinational load-use hazard to upstream stages
//            stall_cnt - saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [DW-1:0]        id_rdata1,
    input  logic [DW-1:0]        id_rdata2,
    input  logic [DW-1:0]        id_imm,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_uses_rt,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 id_memwrite,
    input  logic                 id_memtoreg,
    input  logic                 id_alusrc,
    input  logic                 id_regdst,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic                 ex_memwrite,
    output logic                 ex_memtoreg,
    output logic                 ex_alusrc,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [DW-1:0]        ex_rdata1,
    output logic [DW-1:0]        ex_rdata2,
    output logic [DW-1:0]        ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs,
    output logic [REG_IDX_W-1:0] ex_rt,
    output logic [REG_IDX_W-1:0] ex_wreg,
    output logic                 stall,
    output logic [CNTW-1:0]      stall_cnt
);

    logic                 valid_d,  valid_q;
    ex_ctrl_t             ctrl_d,   ctrl_q;
    logic [ALUOP_W-1:0]   aluop_d,  aluop_q;
    logic [DW-1:0]        rdata1_d, rdata1_q;
    logic [DW-1:0]        rdata2_d, rdata2_q;
    logic [DW-1:0]        imm_d,    imm_q;
    logic [REG_IDX_W-1:0] rs_d,     rs_q;
    logic [REG_IDX_W-1:0] rt_d,     rt_q;
    logic [REG_IDX_W-1:0] wreg_d,   wreg_q;
    logic [CNTW-1:0]      cnt_d,    cnt_q;

    hazard_detect u_hazard_detect (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q.memread),
        .ex_rt      (rt_q),
        .id_valid   (id_valid),
        .flush      (flush),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .stall      (stall)
    );

    // Data and index fields are always captured; only the control bits decide
    // whether EX sees a real instruction or a bubble. Flush and stall both
    // collapse to the same bubble, so their relative priority is moot here.
    always_comb begin
        valid_d          = id_valid & ~flush & ~stall;
        ctrl_d           = '0;
        ctrl_d.regwrite  = id_regwrite;
        ctrl_d.memread   = id_memread;
        ctrl_d.memwrite  = id_memwrite;
        ctrl_d.memtoreg  = id_memtoreg;
        ctrl_d.alusrc    = id_alusrc;
        if (!valid_d) begin
            ctrl_d = ctrl_bubble(ctrl_d);
        end
        aluop_d  = id_aluop;
        rdata1_d = id_rdata1;
        rdata2_d = id_rdata2;
        imm_d    = id_imm;
        rs_d     = id_rs;
        rt_d     = id_rt;
        wreg_d   = id_regdst ? id_rd : id_rt;

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            aluop_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            wreg_q   <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            aluop_q  <= aluop_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            wreg_q   <= wreg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_aluop    = aluop_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_wreg     = wreg_q;
    assign stall_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_reg
// Purpose  : Self-checking bench for id_ex_reg. A second instance with a
//            2-bit stall counter shares all inputs to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt, id_regwrite, id_memread, id_memwrite;
    logic        id_memtoreg, id_alusrc, id_regdst;
    logic [3:0]  id_aluop;
    logic        flush;

    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wreg;
    logic        stall;
    logic [15:0] stall_cnt;

    logic        s_valid, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_alusrc;
    logic [3:0]  s_aluop;
    logic [31:0] s_rdata1, s_rdata2, s_imm;
    logic [4:0]  s_rs, s_rt, s_wreg;
    logic        s_stall;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    id_ex_reg #(.DW(DW), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_aluop(id_aluop), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    id_ex_reg #(.DW(DW), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_aluop(id_aluop), .flush(flush),
        .ex_valid(s_valid), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
        .ex_memwrite(s_memwrite), .ex_memtoreg(s_memtoreg), .ex_alusrc(s_alusrc),
        .ex_aluop(s_aluop), .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_wreg(s_wreg),
        .stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    // ---------------- reference model: what EX should hold ----------------
    bit          m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_alusrc;
    bit [3:0]    m_aluop;
    bit [31:0]   m_rdata1, m_rdata2, m_imm;
    bit [4:0]    m_rs, m_rt, m_wreg;
    int          m_cnt, m_cnt_sat;

    int errors = 0;
    int checks = 0;

    function automatic bit model_stall();
        bit hit;
        if (!(m_valid && m_memread) || m_rt == 5'd0) return 1'b0;
        if (!id_valid || flush) return 1'b0;
        hit = (m_rt == id_rs) || (id_uses_rt && m_rt == id_rt);
        return hit;
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge(input bit stalled);
        if (rst) begin
            {m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_alusrc} = '0;
            m_aluop = 0; m_rdata1 = 0; m_rdata2 = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_wreg = 0;
            m_cnt = 0; m_cnt_sat = 0;
        end else begin
            if (stalled) begin
                m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : 3;
            end
            if (flush || stalled || !id_valid) begin
                {m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg} = '0;
            end else begin
                m_valid = 1; m_regwrite = id_regwrite; m_memread = id_memread;
                m_memwrite = id_memwrite; m_memtoreg = id_memtoreg; m_alusrc = id_alusrc;
                m_aluop = id_aluop; m_rdata1 = id_rdata1; m_rdata2 = id_rdata2;
                m_imm = id_imm; m_rs = id_rs; m_rt = id_rt;
                m_wreg = id_regdst ? id_rd : id_rt;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid",    64'(ex_valid),    64'(m_valid));
        chk("ex_regwrite", 64'(ex_regwrite), 64'(m_regwrite));
        chk("ex_memread",  64'(ex_memread),  64'(m_memread));
        chk("ex_memwrite", 64'(ex_memwrite), 64'(m_memwrite));
        chk("ex_memtoreg", 64'(ex_memtoreg), 64'(m_memtoreg));
        chk("stall_cnt",   64'(stall_cnt),   64'(m_cnt));
        chk("stall_cnt_sat", 64'(s_stall_cnt), 64'(m_cnt_sat));
        if (m_valid) begin
            chk("ex_alusrc", 64'(ex_alusrc), 64'(m_alusrc));
            chk("ex_aluop",  64'(ex_aluop),  64'(m_aluop));
            chk("ex_rdata1", 64'(ex_rdata1), 64'(m_rdata1));
            chk("ex_rdata2", 64'(ex_rdata2), 64'(m_rdata2));
            chk("ex_imm",    64'(ex_imm),    64'(m_imm));
            chk("ex_rs",     64'(ex_rs),     64'(m_rs));
            chk("ex_rt",     64'(ex_rt),     64'(m_rt));
            chk("ex_wreg",   64'(ex_wreg),   64'(m_wreg));
        end
    endtask

    // Inputs are already applied; check stall, clock once, check EX state.
    task automatic cycle();
        bit st;
        #1;
        st = model_stall();
        chk("stall", 64'(stall), 64'(st));
        @(posedge clk);
        model_edge(st);
        #1;
        check_outputs();
    endtask

    task automatic rand_inputs(input int max_idx);
        id_valid    = 1'($urandom);
        id_rdata1   = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
        id_rs       = 5'($urandom_range(max_idx, 0));
        id_rt       = 5'($urandom_range(max_idx, 0));
        id_rd       = 5'($urandom_range(31, 0));
        id_uses_rt  = 1'($urandom);
        id_regwrite = 1'($urandom); id_memread  = 1'($urandom);
        id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
        id_alusrc   = 1'($urandom); id_regdst   = 1'($urandom);
        id_aluop    = 4'($urandom);
        flush       = ($urandom_range(9, 0) == 0);
    endtask

    task automatic set_nop();
        id_valid = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst} = '0;
        id_aluop = 0; flush = 0;
    endtask

    task automatic set_lw(input logic [4:0] rt);
        set_nop();
        id_valid = 1; id_rs = 5'd29; id_rt = rt; id_imm = 32'h10;
        id_regwrite = 1; id_memread = 1; id_memtoreg = 1; id_alusrc = 1; id_regdst = 0;
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_nop();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = 1;
        id_rdata1 = 32'hA5A5_0001; id_rdata2 = 32'h0000_0002;
        id_regwrite = 1; id_regdst = 1; id_aluop = 4'd0;
    endtask

    initial begin
        // Reset for two cycles with random inputs.
        rst = 1;
        rand_inputs(31);
        @(posedge clk);
        model_edge(1'b0);
        #1;
        rand_inputs(31);
        cycle();
        chk("reset_valid", 64'(ex_valid), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_cnt", 64'(stall_cnt), 64'd0);
        chk("reset_wreg", 64'(ex_wreg), 64'd0);
        chk("reset_rdata1", 64'(ex_rdata1), 64'd0);
        rst = 0;

        // Passthrough.
        set_nop();
        id_valid = 1; id_rdata1 = 32'h1234_5678; id_rd = 5'd5; id_rt = 5'd9;
        id_regdst = 1; id_regwrite = 1;
        cycle();
        chk("pass_rdata1", 64'(ex_rdata1), 64'h1234_5678);
        chk("pass_wreg", 64'(ex_wreg), 64'd5);
        chk("pass_regwrite", 64'(ex_regwrite), 64'd1);

        // Load-use: lw rt=8, then add rs=8.
        set_lw(5'd8);  cycle();
        set_add(5'd8, 5'd3, 5'd10);
        #1 chk("lu_stall", 64'(stall), 64'd1);
        cycle();
        chk("lu_bubble", 64'(ex_valid), 64'd0);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
        cycle();
        chk("lu_stall_release", 64'(stall), 64'd0);
        chk("lu_captured", 64'(ex_valid), 64'd1);
        chk("lu_captured_wreg", 64'(ex_wreg), 64'd10);

        // No false hazard: load to $zero, and rt match without use of rt.
        set_lw(5'd0);  cycle();
        set_add(5'd0, 5'd0, 5'd4);
        #1 chk("nofalse_zero", 64'(stall), 64'd0);
        cycle();
        set_lw(5'd8);  cycle();
        set_add(5'd3, 5'd8, 5'd4); id_uses_rt = 0;
        #1 chk("nofalse_rt", 64'(stall), 64'd0);
        cycle();

        // Flush together with a hazard.
        set_lw(5'd8);  cycle();
        set_add(5'd8, 5'd3, 5'd10); flush = 1;
        #1 chk("flush_stall", 64'(stall), 64'd0);
        cycle();
        chk("flush_bubble", 64'(ex_valid), 64'd0);
        chk("flush_cnt", 64'(stall_cnt), 64'd1);

        // Reset in the middle of a stall.
        set_lw(5'd7);  cycle();
        set_add(5'd7, 5'd3, 5'd12); rst = 1;
        cycle();
        chk("rst_mid_cnt", 64'(stall_cnt), 64'd0);
        rst = 0;
        #1 chk("rst_mid_stall", 64'(stall), 64'd0);
        cycle();
        chk("rst_mid_capture", 64'(ex_valid), 64'd1);
        chk("rst_mid_wreg", 64'(ex_wreg), 64'd12);

        // Saturation of the 2-bit counter: five load-use events.
        for (int i = 0; i < 5; i++) begin
            set_lw(5'd9);  cycle();
            set_add(5'd9, 5'd1, 5'd2); cycle();
            cycle();
        end
        chk("sat_cnt", 64'(s_stall_cnt), 64'd3);
        chk("sat_cnt_wide", 64'(stall_cnt), 64'd5);

        // Randomised traffic with a small index range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(3);
            if (id_valid && $urandom_range(2, 0) == 0) id_memread = 1;
            rst = ($urandom_range(49, 0) == 0);
            cycle();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
